// File: rtl/audio_pkg.sv
// audio_pkg: constants, FSM state type and the Hamming coefficient table shared
// by the windowing stage (hamming_window, window_rom).
package audio_pkg;

   localparam int FRAME_LEN = 256;
   localparam int SAMPLE_W  = 12;
   localparam int COEF_W    = 16;
   localparam int COEF_FRAC = 15;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } win_state_t;

   typedef logic [FRAME_LEN-1:0][COEF_W-1:0] coef_tbl_t;

   localparam real PI = 3.14159265358979323846;

   // Evaluated at elaboration: w[n] = round(32768 * (0.54 - 0.46*cos(2*pi*n/(N-1)))).
   // The peak stays just below 1.0, so every entry fits unsigned Q1.15.
   function automatic coef_tbl_t gen_hamming();
      coef_tbl_t tbl;
      real       v;
      tbl = '0;
      for (int n = 0; n < FRAME_LEN; n++) begin
         v = 32768.0 * (0.54 - 0.46 * $cos(2.0 * PI * n / (FRAME_LEN - 1)));
         tbl[n] = COEF_W'($rtoi(v + 0.5));
      end
      return tbl;
   endfunction

   localparam coef_tbl_t HAMMING_COEF = gen_hamming();

endpackage

// File: rtl/window_rom.sv
// window_rom: combinational lookup of the Q1.15 Hamming coefficient for a
// sample index.
module window_rom
   import audio_pkg::*;
(
   input  logic [IDX_W-1:0]  idx,
   output logic [COEF_W-1:0] coef
);

   assign coef = HAMMING_COEF[idx];

endmodule

// File: rtl/hamming_window.sv
// hamming_window: ping-pong capture of 256-sample frames, offset-centring, Hamming
// weighting and valid/ready streaming. Define WINDOW_ROUND_EN for round-half-up scaling.
module hamming_window
   import audio_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [SAMPLE_W-1:0]        frame_in [0:FRAME_LEN-1],
   input  logic                       frame_ready,
   output logic signed [SAMPLE_W-1:0] win_data,
   output logic                       win_valid,
   input  logic                       win_ready,
   output logic [IDX_W-1:0]           win_index,
   output logic                       win_last,
   output logic                       busy,
   output logic                       overrun
);

   localparam int PROD_W = SAMPLE_W + COEF_W + 2;
   localparam int MID    = 1 << (SAMPLE_W - 1);
   localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(MID - 1);
   localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(-MID);

   win_state_t                 state_q, state_d;
   logic [1:0]                 full_q, full_d;
   logic                       rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]           rd_idx_q, rd_idx_d;
   logic signed [SAMPLE_W-1:0] data_q, data_d;
   logic                       valid_q, valid_d;
   logic [IDX_W-1:0]           index_q, index_d;
   logic                       last_q, last_d;
   logic                       overrun_q, overrun_d;

   logic [SAMPLE_W-1:0]        bank_q [2][FRAME_LEN];

   logic                       fire;
   logic                       cap_en, cap_bank;
   logic                       load_en, load_bank;
   logic [IDX_W-1:0]           load_idx;
   logic [SAMPLE_W-1:0]        sample;
   logic [COEF_W-1:0]          coef;
   logic signed [SAMPLE_W:0]   centred;
   logic signed [COEF_W:0]     coef_s;
   logic signed [PROD_W-1:0]   prod, prod_adj, scaled;
   logic signed [SAMPLE_W-1:0] sat;

   window_rom u_rom (
      .idx  (load_idx),
      .coef (coef)
   );

   // Datapath for the element about to enter the output register.
   always_comb begin
      sample  = bank_q[load_bank][load_idx];
      centred = $signed({1'b0, sample}) - (SAMPLE_W + 1)'(MID);
      coef_s  = $signed({1'b0, coef});
      prod    = centred * coef_s;
`ifdef WINDOW_ROUND_EN
      prod_adj = prod + PROD_W'(1 << (COEF_FRAC - 1));
`else
      prod_adj = prod;
`endif
      scaled = prod_adj >>> COEF_FRAC;
      if (scaled > SAT_HI) begin
         sat = SAT_HI[SAMPLE_W-1:0];
      end else if (scaled < SAT_LO) begin
         sat = SAT_LO[SAMPLE_W-1:0];
      end else begin
         sat = scaled[SAMPLE_W-1:0];
      end
   end

   // Output handshake: a sample moves on a clock edge where win_valid && win_ready;
   // while win_valid is high and win_ready low, data/index/last hold, and
   // win_valid never drops until the frame's last sample has transferred.
   always_comb begin
      state_d   = state_q;
      full_d    = full_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      data_d    = data_q;
      valid_d   = valid_q;
      index_d   = index_q;
      last_d    = last_q;
      overrun_d = overrun_q;
      cap_en    = 1'b0;
      cap_bank  = 1'b0;
      load_en   = 1'b0;
      load_bank = rd_bank_q;
      load_idx  = rd_idx_q;
      fire      = valid_q & win_ready;

      // Drop decision uses the flags as they stood before any release this cycle.
      if (frame_ready) begin
         if (&full_q) begin
            overrun_d = 1'b1;
         end else begin
            cap_en   = 1'b1;
            cap_bank = (state_q == ST_STREAM) ? ~rd_bank_q : full_q[0];
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (|full_q) begin
               state_d   = ST_STREAM;
               rd_bank_d = ~full_q[0];
               rd_idx_d  = '0;
            end
         end
         ST_STREAM: begin
            if (fire && last_q) begin
               full_d[rd_bank_q] = 1'b0;
               if (full_q[~rd_bank_q]) begin
                  load_en   = 1'b1;
                  load_bank = ~rd_bank_q;
                  load_idx  = '0;
                  rd_bank_d = ~rd_bank_q;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end
            end else if (!valid_q || fire) begin
               load_en = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (cap_en) begin
         full_d[cap_bank] = 1'b1;
      end

      if (load_en) begin
         valid_d  = 1'b1;
         data_d   = sat;
         index_d  = load_idx;
         last_d   = (load_idx == IDX_W'(FRAME_LEN - 1));
         rd_idx_d = load_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         full_q    <= '0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         index_q   <= '0;
         last_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         full_q    <= full_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         index_q   <= index_d;
         last_q    <= last_d;
         overrun_q <= overrun_d;
      end
   end

   // Bank storage carries no reset; the full flags alone say what is live.
   always_ff @(posedge clk) begin
      if (cap_en) begin
         for (int i = 0; i < FRAME_LEN; i++) begin
            bank_q[cap_bank][i] <= frame_in[i];
         end
      end
   end

   assign win_data  = data_q;
   assign win_valid = valid_q;
   assign win_index = index_q;
   assign win_last  = last_q;
   assign busy      = |full_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_hamming_window.sv
// tb_hamming_window: directed + randomized bench for hamming_window with a
// real-arithmetic reference model and a frame-level bank occupancy model.
module tb_hamming_window;

   localparam real PI = 3.14159265358979323846;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [11:0]        frame_in [0:255];
   logic               frame_ready = 1'b0;
   logic signed [11:0] win_data;
   logic               win_valid;
   logic               win_ready = 1'b0;
   logic [7:0]         win_index;
   logic               win_last;
   logic               busy;
   logic               overrun;

   int                 checks = 0;
   int                 failures = 0;
   int                 coef_tab [256];
   logic [20:0]        exp_q [$];
   int                 open_frames = 0;
   logic               exp_overrun = 1'b0;
   logic signed [11:0] seen [256];
   int                 cyc = 0;
   int                 xfers = 0;
   int                 first_cyc = -1;
   int                 last_cyc = -1;
   int                 lat;

   hamming_window dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_in    (frame_in),
      .frame_ready (frame_ready),
      .win_data    (win_data),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_index   (win_index),
      .win_last    (win_last),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic signed [31:0] got,
                      input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Windowed value straight from the arithmetic definition, in reals.
   function automatic int exp_sample(input int x, input int n);
      real r;
      int  y;
      r = real'((x - 2048) * coef_tab[n]) / 32768.0;
`ifdef WINDOW_ROUND_EN
      r = r + 0.5;
`endif
      y = $rtoi($floor(r));
      if (y > 2047) y = 2047;
      if (y < -2048) y = -2048;
      return y;
   endfunction

   // One clock: observe at the falling edge, update the model, step past the rising edge.
   task automatic tick();
      logic [20:0] e;
      logic        drop;
      drop = 1'b0;
      @(negedge clk);
      chk("busy", busy, open_frames > 0);
      chk("overrun", overrun, exp_overrun);
      if (win_valid) begin
         if (exp_q.size() == 0) begin
            chk("valid_without_frame", win_valid, 0);
         end else begin
            e = exp_q[0];
            chk("data", win_data, $signed(e[11:0]));
            chk("index", win_index, e[19:12]);
            chk("last", win_last, e[20]);
         end
      end else if (exp_q.size() != 0 && exp_q[0][19:12] != 8'd0) begin
         chk("valid_gap", win_valid, 1);
      end
      if (frame_ready) begin
         if (open_frames >= 2) begin
            drop = 1'b1;
         end else begin
            for (int n = 0; n < 256; n++) begin
               exp_q.push_back({n == 255, 8'(n), 12'(exp_sample(frame_in[n], n))});
            end
            open_frames++;
         end
      end
      if (win_valid && win_ready && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         seen[e[19:12]] = win_data;
         if (e[20]) open_frames--;
         xfers++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (drop) exp_overrun = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic fill_frame(input int kind, input int val);
      for (int n = 0; n < 256; n++) begin
         frame_in[n] = (kind == 0) ? 12'(val) : 12'($urandom_range(0, 4095));
      end
   endtask

   task automatic pulse_frame();
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      lat = 0;
      while (!win_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk(tag, lat, 2);
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 4000) begin
         tick();
         k++;
      end
      chk(tag, exp_q.size(), 0);
      tick();
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_data"}, win_data, 0);
      chk({tag, "_valid"}, win_valid, 0);
      chk({tag, "_index"}, win_index, 0);
      chk({tag, "_last"}, win_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      for (int n = 0; n < 256; n++) begin
         coef_tab[n] = $rtoi(32768.0 * (0.54 - 0.46 * $cos(2.0 * PI * n / 255.0)) + 0.5);
         frame_in[n] = 12'd0;
         seen[n] = 12'sd0;
      end

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      win_ready = 1'b1;
      tick();

      // Mid-scale frame windows to zero
      fill_frame(0, 2048);
      pulse_frame();
      wait_valid("lat_2048");
      drain("drain_2048");
      for (int n = 0; n < 256; n++) chk("zero_out", seen[n], 0);

      // Full-scale frame
      fill_frame(0, 4095);
      pulse_frame();
      wait_valid("lat_4095");
      drain("drain_4095");
`ifdef WINDOW_ROUND_EN
      chk("n0_4095", seen[0], 164);
      chk("n127_4095", seen[127], 2047);
`else
      chk("n0_4095", seen[0], 163);
      chk("n127_4095", seen[127], 2046);
`endif

      // Zero frame
      fill_frame(0, 0);
      pulse_frame();
      drain("drain_0");
      chk("n0_zero", seen[0], -164);
      chk("n128_zero", seen[128], -2048);

      // Back-to-back frames at full throughput
      xfers = 0;
      first_cyc = -1;
      for (int f = 0; f < 4; f++) begin
         fill_frame(1, 0);
         pulse_frame();
         repeat (255) tick();
      end
      drain("drain_b2b");
      chk("b2b_xfers", xfers, 1024);
      chk("b2b_span", last_cyc - first_cyc, 1023);
      chk("b2b_overrun", overrun, 0);

      // Stall while three frames arrive; the third is dropped
      win_ready = 1'b0;
      xfers = 0;
      for (int f = 0; f < 3; f++) begin
         fill_frame(1, 0);
         pulse_frame();
         repeat (199) tick();
      end
      chk("stall_overrun", overrun, 1);
      chk("stall_xfers", xfers, 0);
      win_ready = 1'b1;
      drain("drain_stall");
      chk("stall_streamed", xfers, 512);
      chk("stall_sticky", overrun, 1);

      // Reset in the middle of a frame
      fill_frame(1, 0);
      pulse_frame();
      lat = 0;
      while (!(win_valid && win_index == 8'd100) && lat < 400) begin
         tick();
         lat++;
      end
      chk("reach_n100", win_index, 100);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      exp_q.delete();
      open_frames = 0;
      exp_overrun = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      fill_frame(1, 0);
      pulse_frame();
      wait_valid("lat_after_reset");
      chk("restart_index", win_index, 0);
      drain("drain_after_reset");

      // Random frames, random gaps, random backpressure
      for (int f = 0; f < 6; f++) begin
         fill_frame(1, 0);
         pulse_frame();
         repeat ($urandom_range(150, 400)) begin
            win_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      win_ready = 1'b1;
      drain("drain_random");
      chk("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hamming_window.md
# hamming_window

Downstream of the framing stage: captures each 256-sample frame on `frame_ready`, offset-centres every sample, multiplies it by a Hamming coefficient, and streams the windowed samples to the FFT stage over a valid/ready handshake. Ping-pong capture banks let a new frame land while the previous one is still streaming. At full downstream throughput there are no gaps and no lost frames.

## Interface
- `FRAME_LEN`, 256: samples per frame; must equal the framing stage length.
- `SAMPLE_W`, 12: input and output sample width.
- `COEF_FRAC`, 15: fractional bits of the Q1.15 window coefficients.
- `clk`  in  1: system clock; all logic on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `frame_in[0:FRAME_LEN-1]`  in  SAMPLE_W each: unsigned frame from framing; stable in the cycle `frame_ready` is high.
- `frame_ready`  in  1: single-cycle pulse; the frame is valid this cycle.
- `win_data`  out  SAMPLE_W signed: windowed sample.
- `win_valid`  out  1: `win_data`, `win_index` and `win_last` are valid.
- `win_ready`  in  1: downstream accepts the sample. A transfer happens when `win_valid` and `win_ready` are both high.
- `win_index`  out  8: index n (0..255) of the current sample.
- `win_last`  out  1: high with n = FRAME_LEN-1.
- `busy`  out  1: high while any bank holds an unfinished frame.
- `overrun`  out  1: sticky; a frame was dropped.

## Operation
- Bank state
  - Two banks (0/1), each with a `full` flag.
  - `rd_bank` selects the bank being streamed; `rd_idx` is an 8-bit read index.
- Capture
  - On `frame_ready`, copy all of `frame_in` in one cycle into the non-streaming bank and set its `full` flag.
  - If both banks are full, drop the frame, leave both banks untouched, and set `overrun`.
- FSM `IDLE` → `STREAM`
  - `IDLE`: when any bank is full, select it, set `rd_idx` = 0, go to `STREAM`.
  - `STREAM`: the output register loads element `rd_idx` when it is empty or a transfer occurs; then `rd_idx` increments.
  - On the transfer of n = 255, clear that bank's `full` flag.
  - If the other bank is full, switch to it in the same cycle with `rd_idx` = 0 and no bubble. Otherwise return to `IDLE`.
- Arithmetic
  - Centre: s = {1'b0, x} − 2048, signed 13-bit, range −2048..2047.
  - Multiply: p = s × w[n], where w is unsigned 16-bit zero-extended to 17; p is signed 30-bit.
  - Scale: y = p >>> 15 (arithmetic shift; truncation toward −∞).
  - Saturate y to −2048..2047.
- Coefficients
  - w[n] = round(32768·(0.54 − 0.46·cos(2πn/255))).
  - w[0] = w[255] = 2621; w[127] = w[128] = 32767.
- Simultaneous capture and final transfer in the same cycle
  - The capture is evaluated against the `full` flags as they stood before this cycle's release. A frame arriving while both banks are full is dropped, even if one bank frees in that cycle.
- Reset mid-operation
  - Clears both `full` flags and the FSM; the partially streamed frame is abandoned.
  - Bank contents need not be cleared.

## Timing
- Reset values: `win_data` = 0, `win_valid` = 0, `win_index` = 0, `win_last` = 0, `busy` = 0, `overrun` = 0, FSM = `IDLE`.
- Latency: `frame_ready` sampled at edge T → bank full at T → `win_valid` high after edge T+2 with n = 0.
- Throughput: one sample per cycle while `win_ready` = 1. 256 samples take 256 cycles, matching the frame period, so there is no overrun.
- While `win_valid` = 1 and `win_ready` = 0: `win_data`, `win_index` and `win_last` hold.
- `win_valid` never drops mid-frame.
- `overrun` rises the cycle after the dropped pulse.

## Configuration
- `WINDOW_ROUND_EN` defined: add 2^14 to p before the shift (round half up), then saturate.
- `WINDOW_ROUND_EN` undefined: plain truncating shift.
- Handshake and latency are identical in both builds.

## Structure
- `audio_pkg`
  - Constants: `FRAME_LEN`, `SAMPLE_W`, `COEF_W` = 16, `COEF_FRAC`.
  - The 256-entry `HAMMING_COEF` constant array.
  - The FSM state enum.
- Sub-module `window_rom`: combinational 8-bit index → 16-bit coefficient, sourced from `audio_pkg`.

## Test plan
- Constant frame of 2048s, `win_ready` = 1 → 256 outputs all 0; `win_last` only at n = 255; `win_valid` first high 2 cycles after `frame_ready`.
- Frame of 4095s → n = 0 gives 163 (truncating) or 164 (`WINDOW_ROUND_EN`); n = 127 gives 2046 or 2047.
- Frame of 0s → n = 0 gives −164 in both builds; n = 128 gives −2048.
- Frames every 256 cycles with `win_ready` = 1 for 4 frames → 1024 contiguous transfers, `overrun` = 0, no bubble at frame boundaries.
- Hold `win_ready` = 0 for 600 cycles while 3 frames arrive → third frame dropped, `overrun` = 1 and stays set; outputs held; the first two frames stream intact afterwards.
- Deassert `rst_n` at n = 100 → all outputs at reset values immediately; the next frame streams from n = 0.
